// File: rtl/seq_frame_tx_1011.sv
// seq_frame_tx_1011 -- serial frame transmitter for the 1011 sync-word link.
//
// Accepts one DATA_W-bit word per valid/ready handshake and emits the frame
// one bit per clock: sync word 1011, payload MSB first, optional even parity
// bit, then GAP_CYCLES idle cycles before the next word can be accepted.
//
// Optional feature macro: PARITY_EN
//   defined   -> one parity bit (^payload) follows the payload, frame = 5+DATA_W
//   undefined -> no parity state, frame = 4+DATA_W
//
// Ports:
//   clk         clock, all state updates on posedge
//   reset       synchronous active-high reset
//   in_data     payload word, sampled on the handshake edge
//   in_valid    in_data is valid
//   in_ready    block accepts a word this cycle (IDLE only)
//   out_bit     serial bit: sync, payload MSB first, parity
//   out_valid   out_bit belongs to a frame
//   busy        state is not IDLE
//   frame_done  one-cycle pulse while the last frame bit is driven

module seq_frame_tx_1011 #(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_bit,
    output logic              out_valid,
    output logic              busy,
    output logic              frame_done
);

    localparam int MAX_A    = (DATA_W > 4) ? DATA_W : 4;
    localparam int MAX_CNT  = (GAP_CYCLES > MAX_A) ? GAP_CYCLES : MAX_A;
    localparam int CNT_W    = $clog2(MAX_CNT + 1);
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [3:0] SYNC_WORD = 4'b1011;

`ifdef PARITY_EN
    typedef enum logic [2:0] {IDLE, SYNC, DATA, PARITY, GAP} state_t;
`else
    typedef enum logic [2:0] {IDLE, SYNC, DATA, GAP} state_t;
`endif

    // State entered after the last frame bit: skip GAP entirely when it has no cycles.
    localparam state_t AFTER_FRAME = (GAP_CYCLES > 0) ? GAP : IDLE;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [DATA_W-1:0] shreg, shreg_n;
`ifdef PARITY_EN
    logic              par, par_n;
`endif

    logic ready_c, valid_c, bit_c, done_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
`ifdef PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            shreg <= shreg_n;
`ifdef PARITY_EN
            par   <= par_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
`ifdef PARITY_EN
        par_n   = par;
`endif
        ready_c = 1'b0;
        valid_c = 1'b0;
        bit_c   = 1'b0;
        done_c  = 1'b0;

        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (in_valid) begin
                    state_n = SYNC;
                    cnt_n   = '0;
                    shreg_n = in_data;
`ifdef PARITY_EN
                    // Parity is captured at load since the payload is shifted away.
                    par_n   = ^in_data;
`endif
                end
            end

            SYNC: begin
                valid_c = 1'b1;
                bit_c   = SYNC_WORD[2'd3 - cnt[1:0]];
                if (cnt == CNT_W'(3)) begin
                    state_n = DATA;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            DATA: begin
                valid_c = 1'b1;
                bit_c   = shreg[DATA_W-1];
                shreg_n = shreg << 1;
                if (cnt == CNT_W'(DATA_W - 1)) begin
                    cnt_n = '0;
`ifdef PARITY_EN
                    state_n = PARITY;
`else
                    done_c  = 1'b1;
                    state_n = AFTER_FRAME;
`endif
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

`ifdef PARITY_EN
            PARITY: begin
                valid_c = 1'b1;
                bit_c   = par;
                done_c  = 1'b1;
                cnt_n   = '0;
                state_n = AFTER_FRAME;
            end
`endif

            GAP: begin
                if (cnt == CNT_W'(GAP_LAST)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are forced low while reset is high, so an aborted frame goes
    // quiet in the reset cycle itself rather than one cycle later.
    assign in_ready   = ready_c & ~reset;
    assign out_valid  = valid_c & ~reset;
    assign out_bit    = bit_c   & ~reset;
    assign frame_done = done_c  & ~reset;
    assign busy       = (state != IDLE) & ~reset;

endmodule

// File: tb/tb_seq_frame_tx_1011.sv
module tb_seq_frame_tx_1011;

    localparam int DATA_W = 8;
    localparam int GAP    = 2;
`ifdef PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FLEN = 4 + DATA_W + P;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              out_bit;
    logic              out_valid;
    logic              busy;
    logic              frame_done;

    seq_frame_tx_1011 #(
        .DATA_W     (DATA_W),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_bit    (out_bit),
        .out_valid  (out_valid),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: queue of frame bits still to be sent plus idle gap left.
    bit mq[$];
    int gap_left = 0;

    int          cyc = 0;
    int          hs_cyc = -1;
    int          done_cyc = -1;
    int          ready_cyc = -1;
    int          first_valid_cyc = -1;
    int          done_cnt = 0;
    int          prev_done = -1;
    logic [31:0] prev_cap;
    logic [31:0] cap;
    int          cap_n = 0;
    bit          last_hs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs just after posedge, check/update model at negedge.
    task automatic cycle(input logic r, input logic v, input logic [DATA_W-1:0] d);
        logic [4:0] e;
        @(posedge clk);
        #1;
        reset    = r;
        in_valid = v;
        in_data  = d;
        @(negedge clk);
        cyc++;
        if (r)                 e = 5'b00000;
        else if (mq.size() > 0) e = {1'b0, 1'b1, mq[0], 1'b1, (mq.size() == 1)};
        else if (gap_left > 0)  e = 5'b00010;
        else                    e = 5'b10000;
        check("outputs{ready,valid,bit,busy,done}",
              {27'b0, in_ready, out_valid, out_bit, busy, frame_done}, {27'b0, e});

        last_hs = 1'b0;
        if (r) begin
            mq.delete();
            gap_left = 0;
        end else if (mq.size() > 0) begin
            void'(mq.pop_front());
            if (mq.size() == 0) gap_left = GAP;
        end else if (gap_left > 0) begin
            gap_left--;
        end else if (v) begin
            mq.push_back(1'b1); mq.push_back(1'b0);
            mq.push_back(1'b1); mq.push_back(1'b1);
            for (int i = DATA_W - 1; i >= 0; i--) mq.push_back(d[i]);
            if (P == 1) mq.push_back(^d);
            last_hs         = 1'b1;
            prev_cap        = cap;
            prev_done       = done_cyc;
            hs_cyc          = cyc;
            ready_cyc       = -1;
            done_cyc        = -1;
            first_valid_cyc = -1;
            cap             = '0;
            cap_n           = 0;
        end

        if (out_valid) begin
            if (cap_n == 0) first_valid_cyc = cyc;
            cap = {cap[30:0], out_bit};
            cap_n++;
        end
        if (frame_done) begin
            done_cyc = cyc;
            done_cnt++;
        end
        if (in_ready && ready_cyc < 0 && hs_cyc >= 0 && cyc > hs_cyc) ready_cyc = cyc;
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        bit ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            cycle(1'b0, 1'b1, d);
            ok = last_hs;
        end
        if (!ok) check("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 60 && ready_cyc < 0; i++) cycle(1'b0, 1'b0, DATA_W'($urandom));
        if (ready_cyc < 0) check("ready_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hs;
        int dc;
        int hits;
        logic [31:0] exp_s;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;

        // Reset held with in_valid high: everything quiet, then ready on release.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 8'hA5);
        cycle(1'b0, 1'b0, 8'h00);
        check("t1_ready_after_reset", {31'b0, in_ready}, 32'd1);

        // Single frame A5: stream, frame_done position, in_ready return.
        dc = done_cnt;
        send(8'hA5);
        hs = hs_cyc;
        wait_ready();
        exp_s = (P == 1) ? 32'b1011_10100101_0 : 32'b1011_10100101;
        check("t2_stream_a5", cap, exp_s);
        check("t2_bit_count", cap_n, FLEN);
        check("t2_done_latency", done_cyc - hs, 4 + DATA_W + P);
        check("t2_done_once", done_cnt - dc, 1);
        check("t2_ready_latency", ready_cyc - hs, 5 + DATA_W + P + GAP);

        // Word 07.
        send(8'h07);
        wait_ready();
        exp_s = (P == 1) ? 32'b1011_00000111_1 : 32'b1011_00000111;
        check("t3_stream_07", cap, exp_s);

        // Back-to-back with in_valid held high; in_data switches while busy.
        hits = 0;
        for (int i = 0; i < 80 && hits < 2; i++) begin
            cycle(1'b0, 1'b1, (hits == 0) ? 8'hFF : 8'h00);
            if (last_hs) hits++;
        end
        check("t4_two_handshakes", hits, 2);
        wait_ready();
        exp_s = (P == 1) ? 32'b1011_11111111_0 : 32'b1011_11111111;
        check("t4_first_stream_ff", prev_cap, exp_s);
        exp_s = (P == 1) ? 32'b1011_00000000_0 : 32'b1011_00000000;
        check("t4_second_stream_00", cap, exp_s);
        check("t4_idle_between_frames", first_valid_cyc - prev_done - 1, GAP + 1);

        // Reset at cycle N+6 of a frame aborts it without frame_done.
        dc = done_cnt;
        send(8'h3C);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 8'h00);
        check("t5_valid_low_in_reset", {31'b0, out_valid}, 32'd0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 8'h00);
        check("t5_no_frame_done", done_cnt - dc, 0);
        send(8'h5A);
        wait_ready();
        exp_s = (P == 1) ? 32'b1011_01011010_0 : 32'b1011_01011010;
        check("t5_stream_after_reset", cap, exp_s);

        // Payload 00: the 1011 pattern occurs once, ending at the 4th bit.
        send(8'h00);
        wait_ready();
        hits = 0;
        for (int i = 3; i < cap_n; i++)
            if (cap[cap_n-1-i+3 -: 4] == 4'b1011) begin
                hits++;
                check("t6_sync_end_pos", i, 3);
            end
        check("t6_sync_seen_once", hits, 1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++)
            cycle(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), DATA_W'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
